key_capture: RTL and testbench

//   Sequential stage directly downstream of the multi-button detector. Consumes the 4 button levels
//   and the detector's 'invalid' flag. Qualifies a single-button press held stable, encodes it to a
//   2-bit key code and presents it with a valid/ready handshake. Requires release before the next key.

---
 rtl/key_capture_pkg.sv | 12 +
 rtl/key_capture_sync_2ff.sv | 26 ++
 rtl/key_capture.sv | 142 ++++++++++++++
 tb/tb_key_capture.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/key_capture_pkg.sv
// key_capture_pkg: FSM state encoding and one-hot key encoder shared by key_capture.
package key_capture_pkg;

    typedef enum logic [1:0] {IDLE, QUAL, HOLD, WAIT_REL} state_t;

    localparam int BTN_W = 4;

    function automatic logic [1:0] onehot4_to_idx(input logic [3:0] oh);
        return oh[3] ? 2'd3 : oh[2] ? 2'd2 : oh[1] ? 2'd1 : 2'd0;
    endfunction

endpackage

// File: rtl/key_capture_sync_2ff.sv
// sync_2ff: two-flop synchronizer; all bits share the same stages so they stay aligned.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/key_capture.sv
// key_capture: qualifies a stable single-button press into a 2-bit key with valid/ready handshake.
// Define KEY_CAPTURE_SYNC_EN to pass btn/invalid through a 2-flop synchronizer (+2 cycles latency).
module key_capture
    import key_capture_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BTN_W-1:0] btn,
    input  logic             invalid,
    input  logic             key_ready,
    output logic             key_valid,
    output logic [1:0]       key_code,
    output logic             err_pulse,
    output logic             busy
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [BTN_W-1:0] w_btn;
    logic             w_invalid;

`ifdef KEY_CAPTURE_SYNC_EN
    logic [BTN_W:0] w_sync;

    sync_2ff #(.WIDTH(BTN_W + 1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   ({invalid, btn}),
        .o_q   (w_sync)
    );

    assign {w_invalid, w_btn} = w_sync;
`else
    assign w_btn     = btn;
    assign w_invalid = invalid;
`endif

    state_t           r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [BTN_W-1:0] r_cand, w_cand_nx;
    logic             r_valid, w_valid_nx;
    logic [1:0]       r_code, w_code_nx;
    logic             r_err, w_err_nx;
    logic             r_busy;
    logic             w_zero;
    logic             w_last;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_zero    = (w_btn == '0);
    assign w_last    = (r_cnt == CNT_LAST);
    // terminal compare gates the increment so the counter never wraps
    assign w_cnt_inc = w_last ? r_cnt : r_cnt + CNT_W'(1);

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_cand_nx  = r_cand;
        w_valid_nx = r_valid;
        w_code_nx  = r_code;
        w_err_nx   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_zero) begin
                    w_state_nx = IDLE;
                end else if (w_invalid) begin
                    w_state_nx = WAIT_REL;
                    w_cnt_nx   = '0;
                    w_err_nx   = 1'b1;
                end else begin
                    w_state_nx = QUAL;
                    w_cand_nx  = w_btn;
                    w_cnt_nx   = CNT_W'(1);
                end
            end
            QUAL: begin
                if (w_invalid) begin
                    w_state_nx = WAIT_REL;
                    w_cnt_nx   = '0;
                    w_err_nx   = 1'b1;
                end else if (w_zero) begin
                    w_state_nx = IDLE;
                    w_cnt_nx   = '0;
                end else if (w_btn != r_cand) begin
                    w_cand_nx = w_btn;
                    w_cnt_nx  = CNT_W'(1);
                end else if (w_last) begin
                    w_state_nx = HOLD;
                    w_valid_nx = 1'b1;
                    w_code_nx  = onehot4_to_idx(r_cand);
                end else begin
                    w_cnt_nx = w_cnt_inc;
                end
            end
            HOLD: begin
                if (r_valid && key_ready) begin
                    w_state_nx = WAIT_REL;
                    w_valid_nx = 1'b0;
                    w_cnt_nx   = '0;
                end
            end
            WAIT_REL: begin
                if (!w_zero) begin
                    w_cnt_nx = '0;
                end else if (w_last) begin
                    w_state_nx = IDLE;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = w_cnt_inc;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_cand  <= '0;
            r_valid <= 1'b0;
            r_code  <= 2'd0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_cand  <= w_cand_nx;
            r_valid <= w_valid_nx;
            r_code  <= w_code_nx;
            r_err   <= w_err_nx;
            r_busy  <= (w_state_nx != IDLE);
        end
    end

    assign key_valid = r_valid;
    assign key_code  = r_code;
    assign err_pulse = r_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_key_capture.sv
// tb_key_capture: table-driven and hand-sequenced checks of key_capture with a key scoreboard.
module tb_key_capture;

    localparam int SC = 4;
`ifdef KEY_CAPTURE_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn = 4'd0;
    logic       invalid = 1'b0;
    logic       key_ready = 1'b0;
    logic       key_valid;
    logic [1:0] key_code;
    logic       err_pulse;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int n_keys = 0;
    int n_errp = 0;
    logic [1:0] sb[$];

    typedef struct {
        logic [3:0] b;
        logic       inv;
        int         hold;
        int         keys;
        logic [1:0] code;
        int         errs;
    } vec_t;

    vec_t v[8];

    key_capture #(.STABLE_CYCLES(SC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn       (btn),
        .invalid   (invalid),
        .key_ready (key_ready),
        .key_valid (key_valid),
        .key_code  (key_code),
        .err_pulse (err_pulse),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // handshake monitor: every accepted key must match the next scoreboard entry
    always @(negedge clk) begin
        if (rst_n) begin
            if (err_pulse) n_errp++;
            if (key_valid && key_ready) begin
                n_keys++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_key: got code %0d expected no key", key_code);
                end else begin
                    chk("key_code", int'(key_code), int'(sb.pop_front()));
                end
            end
        end
    end

    task automatic step(input logic [3:0] b, input logic inv, input int n);
        btn = b;
        invalid = inv;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int k0;
        int e0;
        v[0] = '{4'b0001, 1'b0, 6, 1, 2'd0, 0};
        v[1] = '{4'b0010, 1'b0, 6, 1, 2'd1, 0};
        v[2] = '{4'b0100, 1'b0, 4, 1, 2'd2, 0};
        v[3] = '{4'b1000, 1'b0, 3, 0, 2'd0, 0};
        v[4] = '{4'b0010, 1'b0, 2, 0, 2'd0, 0};
        v[5] = '{4'b0011, 1'b1, 3, 0, 2'd0, 1};
        v[6] = '{4'b1100, 1'b1, 1, 0, 2'd0, 1};
        v[7] = '{4'b1000, 1'b0, 8, 1, 2'd3, 0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", int'(key_valid), 0);
        chk("reset_code", int'(key_code), 0);
        chk("reset_err", int'(err_pulse), 0);
        chk("reset_busy", int'(busy), 0);
        rst_n = 1'b1;
        step(4'd0, 1'b0, 2);

        key_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            k0 = n_keys;
            e0 = n_errp;
            if (v[i].keys != 0) sb.push_back(v[i].code);
            step(v[i].b, v[i].inv, v[i].hold);
            step(4'd0, 1'b0, 8 + SL);
            chk($sformatf("vec%0d_keys", i), n_keys - k0, v[i].keys);
            chk($sformatf("vec%0d_errs", i), n_errp - e0, v[i].errs);
            chk($sformatf("vec%0d_busy", i), int'(busy), 0);
            chk($sformatf("vec%0d_sb", i), sb.size(), 0);
        end

        // latency and one-cycle valid with ready held high
        sb.push_back(2'd2);
        btn = 4'b0100;
        invalid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("lat_valid_%0d", i), int'(key_valid), int'(i == SC + SL));
            if (i == SC + SL) chk("lat_code", int'(key_code), 2);
        end
        step(4'd0, 1'b0, 8 + SL);
        chk("lat_busy", int'(busy), 0);
        chk("lat_sb", sb.size(), 0);

        // candidate change restarts qualification
        k0 = n_keys;
        sb.push_back(2'd1);
        step(4'b0001, 1'b0, 2);
        step(4'b0010, 1'b0, 4);
        step(4'd0, 1'b0, 8 + SL);
        chk("restart_keys", n_keys - k0, 1);

        // multi-press during qualification
        k0 = n_keys;
        e0 = n_errp;
        step(4'b0001, 1'b0, 2);
        step(4'b0011, 1'b1, 1);
        step(4'd0, 1'b0, 8 + SL);
        chk("qual_inv_keys", n_keys - k0, 0);
        chk("qual_inv_errs", n_errp - e0, 1);

        // err pulse timing and release requirement
        k0 = n_keys;
        e0 = n_errp;
        btn = 4'b0011;
        invalid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("err_pulse_%0d", i), int'(err_pulse), int'(i == 1 + SL));
        end
        step(4'd0, 1'b0, SC - 1);
        step(4'b0001, 1'b0, 6);
        chk("rel_short_busy", int'(busy), 1);
        step(4'd0, 1'b0, SC);
        sb.push_back(2'd0);
        step(4'b0001, 1'b0, SC);
        step(4'd0, 1'b0, 8 + SL);
        chk("rel_keys", n_keys - k0, 1);
        chk("rel_errs", n_errp - e0, 1);

        // backpressure: key frozen while btn changes
        key_ready = 1'b0;
        step(4'b0001, 1'b0, SC + SL);
        chk("bp_valid_start", int'(key_valid), 1);
        chk("bp_code_start", int'(key_code), 0);
        btn = 4'b1000;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_valid_%0d", i), int'(key_valid), 1);
            chk($sformatf("bp_code_%0d", i), int'(key_code), 0);
        end
        k0 = n_keys;
        sb.push_back(2'd0);
        key_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_drop", int'(key_valid), 0);
        step(4'd0, 1'b0, 8 + SL);
        chk("bp_keys", n_keys - k0, 1);
        chk("bp_sb", sb.size(), 0);

        // async reset while holding a key
        key_ready = 1'b0;
        step(4'b0100, 1'b0, SC + SL);
        chk("rst_hold_valid", int'(key_valid), 1);
        chk("rst_hold_busy", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", int'(key_valid), 0);
        chk("rst_mid_code", int'(key_code), 0);
        chk("rst_mid_err", int'(err_pulse), 0);
        chk("rst_mid_busy", int'(busy), 0);
        btn = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        key_ready = 1'b1;
        k0 = n_keys;
        step(4'd0, 1'b0, 3 + SL);
        chk("rst_after_busy", int'(busy), 0);
        chk("rst_after_valid", int'(key_valid), 0);
        chk("rst_after_keys", n_keys - k0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
